// File: rtl/mod3_pkg.sv
// rtl/mod3_pkg.sv - shared state encoding, residue codes and legality helper for the mod-3 checker
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [1:0] RES0        = 2'b00;
  localparam logic [1:0] RES1        = 2'b01;
  localparam logic [1:0] RES2        = 2'b10;
  localparam logic [1:0] RES_ILLEGAL = 2'b11;

  function automatic logic res_legal(input logic [1:0] res);
    return res != RES_ILLEGAL;
  endfunction

endpackage

// File: rtl/mod3_residue_checker_if.sv
// rtl/mod3_residue_checker_if.sv - input/output handshakes and error-count status of the mod-3 checker
interface mod3_residue_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_residue;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_residue;
  logic              out_err;
  logic              err_clr;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output in_valid, in_data, in_residue, out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_residue, out_err, err_count
  );

  modport slave (
    input  in_valid, in_data, in_residue, out_ready, err_clr,
    output in_ready, out_valid, out_data, out_residue, out_err, err_count
  );

endinterface

// File: rtl/mod3_step.sv
// rtl/mod3_step.sv - one step of the MSB-first mod-3 recurrence, y = (2*r + b) mod 3
module mod3_step
  import mod3_pkg::*;
(
  input  logic [1:0] r,
  input  logic       b,
  output logic [1:0] y
);

  always_comb begin
    y = RES0;
    case (r)
      RES0:    y = b ? RES1 : RES0;
      RES1:    y = b ? RES0 : RES2;
      RES2:    y = b ? RES2 : RES1;
      default: y = RES0;
    endcase
  end

endmodule

// File: rtl/mod3_residue_checker.sv
// rtl/mod3_residue_checker.sv - bit-serial mod-3 residue checker with held result and saturating error count
module mod3_residue_checker
  import mod3_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic rst,
  mod3_residue_checker_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [1:0]        r_q, r_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        tx_res_q, tx_res_d;
  logic [1:0]        out_res_q, out_res_d;
  logic              out_err_q, out_err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        r_step;
  logic              out_hs;

  mod3_step u_step (
    .r (r_q),
    .b (data_q[idx_q]),
    .y (r_step)
  );

  assign out_hs = out_valid_q & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    idx_d     = idx_q;
    data_d    = data_q;
    tx_res_d  = tx_res_q;
    out_res_d = out_res_q;
    out_err_d = out_err_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d   = bus.in_data;
          tx_res_d = bus.in_residue;
          r_d      = RES0;
          idx_d    = IDX_TOP;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        r_d   = r_step;
        idx_d = idx_q - IDX_W'(1);
        // Result registers are loaded only on the final bit so they hold steady through HOLD.
        if (idx_q == '0) begin
          out_res_d = r_step;
          out_err_d = (r_step != tx_res_q) || !res_legal(tx_res_q);
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);

    if (bus.err_clr) begin
      cnt_d = '0;
    end else if (out_hs && out_err_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= RES0;
      idx_q       <= '0;
      data_q      <= '0;
      tx_res_q    <= RES0;
      out_res_q   <= RES0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      tx_res_q    <= tx_res_d;
      out_res_q   <= out_res_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_residue = out_res_q;
  assign bus.out_err     = out_err_q;
  assign bus.err_count   = cnt_q;

endmodule

// File: tb/tb_mod3_residue_checker.sv
// tb/tb_mod3_residue_checker.sv - randomized self-checking bench for the mod-3 residue checker
module tb_mod3_residue_checker;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic             in_valid   = 1'b0;
  logic [7:0]       in_data    = '0;
  logic [1:0]       in_residue = '0;
  logic             out_ready  = 1'b0;
  logic             err_clr    = 1'b0;

  int tests = 0;
  int fails = 0;
  int cnt8_m = 0;
  int cnt2_m = 0;
  int hs_seen = 0;
  int hs_exp = 0;
  longint acc_t = 0;
  longint prev_acc_t = 0;

  mod3_residue_checker_if #(.DATA_W(DATA_W), .CNT_W(8)) b8 ();
  mod3_residue_checker_if #(.DATA_W(DATA_W), .CNT_W(2)) b2 ();

  assign b8.in_valid = in_valid;   assign b2.in_valid = in_valid;
  assign b8.in_data = in_data;     assign b2.in_data = in_data;
  assign b8.in_residue = in_residue; assign b2.in_residue = in_residue;
  assign b8.out_ready = out_ready; assign b2.out_ready = out_ready;
  assign b8.err_clr = err_clr;     assign b2.err_clr = err_clr;

  mod3_residue_checker #(.DATA_W(DATA_W), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  mod3_residue_checker #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && b8.out_valid && out_ready) hs_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout global obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // Called at a negedge with the checker idle; returns at a negedge after the output handshake.
  task automatic send(input logic [7:0] d, input logic [1:0] res, input int hold, input bit clr_hs);
    int lat;
    logic [1:0] er;
    bit ee;
    er = 2'(int'(d) % 3);
    ee = (er != res) || (res == 2'b11);
    chk("in_ready_idle", 32'(b8.in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_residue = res;
    @(posedge clk);
    prev_acc_t = acc_t;
    acc_t = $time;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom); in_residue = 2'($urandom);
    lat = 0;
    while (!b8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(DATA_W));
    chk("out_data", 32'(b8.out_data), 32'(d));
    chk("out_residue", 32'(b8.out_residue), 32'(er));
    chk("out_err", 32'(b8.out_err), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_residue = 2'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(b8.out_valid), 32'd1);
      chk("bp_in_ready", 32'(b8.in_ready), 32'd0);
      chk("bp_data", 32'(b8.out_data), 32'(d));
      chk("bp_residue", 32'(b8.out_residue), 32'(er));
      chk("bp_err", 32'(b8.out_err), 32'(ee));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    err_clr = clr_hs;
    @(posedge clk);
    hs_exp++;
    if (clr_hs) begin
      cnt8_m = 0; cnt2_m = 0;
    end else if (ee) begin
      cnt8_m = sat_inc(cnt8_m, 255);
      cnt2_m = sat_inc(cnt2_m, 3);
    end
    @(negedge clk);
    out_ready = 1'b0;
    err_clr = 1'b0;
    chk("post_hs_valid", 32'(b8.out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(b8.in_ready), 32'd1);
    chk("err_count8", 32'(b8.err_count), 32'(cnt8_m));
    chk("err_count2", 32'(b2.err_count), 32'(cnt2_m));
    chk("hs_count", 32'(hs_seen), 32'(hs_exp));
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rr;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(b8.in_ready), 32'd1);
    chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
    chk("rst_out_data", 32'(b8.out_data), 32'd0);
    chk("rst_out_residue", 32'(b8.out_residue), 32'd0);
    chk("rst_out_err", 32'(b8.out_err), 32'd0);
    chk("rst_err_count", 32'(b8.err_count), 32'd0);

    send(8'hFF, 2'b00, 0, 1'b0);
    send(8'h64, 2'b01, 0, 1'b0);
    send(8'h64, 2'b10, 0, 1'b0);
    chk("gap_10_cycles", 32'(acc_t - prev_acc_t), 32'd100);
    send(8'h05, 2'b11, 0, 1'b0);
    send(8'hA7, 2'b10, 5, 1'b0);

    // Reset during the 4th SHIFT cycle of 0x3C.
    in_valid = 1'b1; in_data = 8'h3C; in_residue = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(b8.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(b8.out_data), 32'd0);
    chk("mid_rst_out_residue", 32'(b8.out_residue), 32'd0);
    chk("mid_rst_out_err", 32'(b8.out_err), 32'd0);
    chk("mid_rst_err_count", 32'(b8.err_count), 32'd0);
    cnt8_m = 0; cnt2_m = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_word", 32'(b8.out_valid), 32'd0);
    chk("mid_rst_hs", 32'(hs_seen), 32'(hs_exp));
    send(8'h3C, 2'b00, 0, 1'b0);

    // Saturation on the 2-bit counter, then clear coincident with an errored handshake.
    for (int k = 0; k < 5; k++) begin
      rd = 8'($urandom);
      rr = 2'((int'(rd) % 3 + 1) % 3);
      send(rd, rr, 0, 1'b0);
    end
    chk("sat_count2", 32'(b2.err_count), 32'd3);
    send(8'h10, 2'b11, 0, 1'b1);
    chk("clr_priority", 32'(b2.err_count), 32'd0);

    for (int k = 0; k < 40; k++) begin
      rd = 8'($urandom);
      rr = ($urandom_range(0, 1) == 0) ? 2'(int'(rd) % 3) : 2'($urandom_range(0, 3));
      send(rd, rr, int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
